// File: rtl/counter_pkg.sv
// Shared definitions for the command-driven counter sequencer.
// Holds the command opcode and FSM state encodings plus the default counter width.
package counter_pkg;

    localparam int unsigned WIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/counter_dp.sv
// WIDTH-bit counter register with clear, load and up/down step.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   clr         - synchronous clear to zero (highest priority)
//   ld, ld_val  - synchronous load of ld_val
//   en, dir     - step enable; dir=1 counts up, dir=0 counts down (modulo 2^WIDTH)
//   q           - registered counter value
//   wrap_next   - the step taken on the coming edge crosses the wrap point
module counter_dp
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             wrap_next
);

    // Only a real step can wrap; clear and load never do.
    assign wrap_next = en && !clr && !ld && (dir ? (q == '1) : (q == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            q <= dir ? q + WIDTH'(1) : q - WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer in front of the counter datapath. Accepts one command at a time
// over valid/ready (LOAD, UP N, DOWN N, CLEAR), runs UP/DOWN as N single steps and
// reports completion (done) and roll-over (wrap) as registered one-cycle pulses.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake; ready only when idle and out of reset
//   cmd_op, cmd_arg     - opcode and LOAD value or step count
//   abort               - stop a running UP/DOWN without stepping or pulsing done
//   q                   - counter value
//   busy                - a sequence is running
//   done, wrap          - one-cycle completion and roll-over pulses
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic             done_d;
    logic             accept;
    logic             dp_clr, dp_ld, dp_en;
    logic             wrap_next;

    // Ready drops combinationally with reset so nothing is accepted while held in reset.
    assign cmd_ready = (state_q == ST_IDLE) && reset;
    assign busy      = (state_q == ST_RUN);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        dp_clr      = 1'b0;
        dp_ld       = 1'b0;
        dp_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op_e'(cmd_op))
                        OP_LOAD: begin
                            dp_ld  = 1'b1;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            dp_clr = 1'b1;
                            done_d = 1'b1;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d     = ST_RUN;
                                remaining_d = cmd_arg;
                                dir_d       = (op_e'(cmd_op) == OP_UP);
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // Abort takes precedence over the step, including the final one.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    dp_en       = 1'b1;
                    remaining_d = remaining_q - WIDTH'(1);
                    if (remaining_q == WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            done        <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            done        <= done_d;
            wrap        <= wrap_next;
        end
    end

    counter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .clr       (dp_clr),
        .ld        (dp_ld),
        .ld_val    (cmd_arg),
        .en        (dp_en),
        .dir       (dir_q),
        .q         (q),
        .wrap_next (wrap_next)
    );

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed command sequence with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_counter_seq_ctrl;

    localparam int W    = 3;
    localparam int MAXV = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_arg;
    logic         abort;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         wrap;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    counter_seq_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counter value, whether a sequence runs, steps left, direction.
    int m_q, m_rem, m_done, m_wrap;
    bit m_run, m_up;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q = 0; m_rem = 0; m_run = 0; m_up = 0; m_done = 0; m_wrap = 0;
        end else begin
            int nd, nw;
            nd = 0;
            nw = 0;
            if (m_run) begin
                if (abort) begin
                    m_run = 0;
                end else begin
                    if (m_up) begin
                        if (m_q == MAXV - 1) nw = 1;
                        m_q = (m_q + 1) % MAXV;
                    end else begin
                        if (m_q == 0) nw = 1;
                        m_q = (m_q + MAXV - 1) % MAXV;
                    end
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin
                        m_run = 0;
                        nd = 1;
                    end
                end
            end else if (cmd_valid) begin
                case (int'(cmd_op))
                    0: begin m_q = int'(cmd_arg); nd = 1; end
                    3: begin m_q = 0; nd = 1; end
                    default: begin
                        if (cmd_arg == 0) nd = 1;
                        else begin
                            m_run = 1;
                            m_rem = int'(cmd_arg);
                            m_up  = (cmd_op == 2'b01);
                        end
                    end
                endcase
            end
            m_done = nd;
            m_wrap = nw;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_q", int'(q), m_q);
            chk("cyc_busy", int'(busy), int'(m_run));
            chk("cyc_done", int'(done), m_done);
            chk("cyc_wrap", int'(wrap), m_wrap);
            chk("cyc_ready", int'(cmd_ready), int'(!m_run && reset));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command and return #1 after the edge that accepts it.
    task automatic issue(input logic [1:0] op, input int arg);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = W'(arg);
        while (n < 20) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
        end
        if (n >= 20) begin
            chk("issue_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_arg   = 3'd5;
        abort     = 1'b0;

        // Reset held with a pending LOAD: nothing may be accepted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        chk_en = 1'b1;
        reset = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("rel_ready", int'(cmd_ready), 1);
        chk("rel_q", int'(q), 0);

        // LOAD 5 then UP 4 across the wrap point.
        issue(2'b00, 5);
        chk("ld5_q", int'(q), 5);
        chk("ld5_done", int'(done), 1);
        issue(2'b01, 4);
        chk("up4_q0", int'(q), 5);
        chk("up4_busy0", int'(busy), 1);
        tick; chk("up4_q1", int'(q), 6); chk("up4_busy1", int'(busy), 1);
        tick; chk("up4_q2", int'(q), 7); chk("up4_busy2", int'(busy), 1);
        tick; chk("up4_q3", int'(q), 0); chk("up4_wrap", int'(wrap), 1);
        chk("up4_busy3", int'(busy), 1); chk("up4_nodone", int'(done), 0);
        tick; chk("up4_q4", int'(q), 1); chk("up4_done", int'(done), 1);
        chk("up4_idle", int'(busy), 0); chk("up4_wrap_off", int'(wrap), 0);

        // CLEAR then DOWN 2, with a LOAD 4 presented while busy.
        issue(2'b11, 0);
        chk("clr_q", int'(q), 0);
        chk("clr_done", int'(done), 1);
        issue(2'b10, 2);
        chk("dn2_q0", int'(q), 0);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 3'd4;
        tick; chk("dn2_q1", int'(q), 7); chk("dn2_wrap", int'(wrap), 1);
        tick; chk("dn2_q2", int'(q), 6); chk("dn2_done", int'(done), 1);
        chk("dn2_idle", int'(busy), 0);
        tick; chk("held_ld_q", int'(q), 4); chk("held_ld_done", int'(done), 1);
        cmd_valid = 1'b0;

        // UP 0, then LOAD 3 accepted during its done cycle.
        tick;
        issue(2'b01, 0);
        chk("up0_q", int'(q), 4);
        chk("up0_done", int'(done), 1);
        chk("up0_busy", int'(busy), 0);
        issue(2'b00, 3);
        chk("b2b_q", int'(q), 3);
        chk("b2b_done", int'(done), 1);
        tick; chk("b2b_done_off", int'(done), 0);

        // LOAD 2, UP 7 aborted at q=4, then UP 1.
        issue(2'b00, 2);
        issue(2'b01, 7);
        tick; chk("ab_q3", int'(q), 3);
        tick; chk("ab_q4", int'(q), 4);
        abort = 1'b1;
        tick; chk("ab_hold", int'(q), 4); chk("ab_idle", int'(busy), 0);
        chk("ab_nodone", int'(done), 0);
        tick; chk("ab_idle_abort", int'(q), 4); chk("ab_nodone2", int'(done), 0);
        abort = 1'b0;
        issue(2'b01, 1);
        chk("up1_busy", int'(busy), 1);
        tick; chk("up1_q", int'(q), 5); chk("up1_done", int'(done), 1);

        // Abort coincident with the final step wins.
        issue(2'b01, 1);
        abort = 1'b1;
        tick; chk("abfin_q", int'(q), 5); chk("abfin_done", int'(done), 0);
        chk("abfin_idle", int'(busy), 0);
        abort = 1'b0;

        // Asynchronous reset in the middle of UP 6 from 1.
        issue(2'b00, 1);
        issue(2'b01, 6);
        tick; tick;
        chk("mid_q", int'(q), 3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cmd_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) begin
            tick;
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_q", int'(q), 0);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
